// File: rtl/calc_driver_pkg.sv
// Shared constants for the calculator command driver: opcodes, FSM encoding,
// command-byte field positions and error-bit indices.
package calc_driver_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StGetB = 2'd1;
   localparam logic [1:0] StExec = 2'd2;
   localparam logic [1:0] StHold = 2'd3;

   // byte0 = {rsv[7:6], op[5:4], a[3:0]}, byte1 = {rsv[7:4], b[3:0]}
   localparam int unsigned B0_A_LSB   = 0;
   localparam int unsigned B0_A_MSB   = 3;
   localparam int unsigned B0_OP_LSB  = 4;
   localparam int unsigned B0_OP_MSB  = 5;
   localparam int unsigned B0_RSV_LSB = 6;
   localparam int unsigned B0_RSV_MSB = 7;
   localparam int unsigned B1_B_LSB   = 0;
   localparam int unsigned B1_B_MSB   = 3;
   localparam int unsigned B1_RSV_LSB = 4;
   localparam int unsigned B1_RSV_MSB = 7;

   localparam int unsigned ERR_DIV0 = 0;
   localparam int unsigned ERR_RSV  = 1;

   function automatic logic is_div0(input logic [1:0] op, input logic [3:0] b);
      return (op == OP_DIV) && (b == 4'd0);
   endfunction

endpackage

// File: rtl/calc_driver.sv
// Collects two-byte commands, drives an external combinational calculator and
// presents the captured result with error flags through a valid/ready port.
module calc_driver
   import calc_driver_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [3:0] calc_a,
   output logic [3:0] calc_b,
   output logic [1:0] calc_op,
   input  logic [7:0] calc_result,
   output logic       res_valid,
   output logic [7:0] res_data,
   output logic [1:0] res_err,
   input  logic       res_ready,
   output logic [7:0] txn_count
);

   logic [1:0] state_q, state_d;
   logic [3:0] calc_a_q, calc_a_d;
   logic [3:0] calc_b_q, calc_b_d;
   logic [1:0] calc_op_q, calc_op_d;
   logic       rsv_q, rsv_d;
   logic [7:0] res_data_q, res_data_d;
   logic [1:0] res_err_q, res_err_d;
   logic [7:0] txn_count_q, txn_count_d;
   logic       accept;
   logic       handshake;

   // Both ready and valid decode only the state register, so res_ready never
   // reaches in_ready combinationally.
   assign in_ready  = (state_q == StIdle) || (state_q == StGetB);
   assign res_valid = (state_q == StHold);
   assign accept    = in_valid && in_ready;
   assign handshake = res_valid && res_ready;

   always_comb begin
      state_d     = state_q;
      calc_a_d    = calc_a_q;
      calc_b_d    = calc_b_q;
      calc_op_d   = calc_op_q;
      rsv_d       = rsv_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
      txn_count_d = txn_count_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               calc_a_d  = in_data[B0_A_MSB:B0_A_LSB];
               calc_op_d = in_data[B0_OP_MSB:B0_OP_LSB];
               rsv_d     = |in_data[B0_RSV_MSB:B0_RSV_LSB];
               state_d   = StGetB;
            end
         end
         StGetB: begin
            if (accept) begin
               calc_b_d = in_data[B1_B_MSB:B1_B_LSB];
               rsv_d    = rsv_q | (|in_data[B1_RSV_MSB:B1_RSV_LSB]);
               state_d  = StExec;
            end
         end
         StExec: begin
            res_data_d          = calc_result;
            res_err_d[ERR_DIV0] = is_div0(calc_op_q, calc_b_q);
            res_err_d[ERR_RSV]  = rsv_q;
            state_d             = StHold;
         end
         StHold: begin
            if (handshake) begin
               txn_count_d = txn_count_q + 8'd1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         calc_a_q    <= 4'd0;
         calc_b_q    <= 4'd0;
         calc_op_q   <= OP_ADD;
         rsv_q       <= 1'b0;
         res_data_q  <= 8'd0;
         res_err_q   <= 2'b00;
         txn_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         calc_a_q    <= calc_a_d;
         calc_b_q    <= calc_b_d;
         calc_op_q   <= calc_op_d;
         rsv_q       <= rsv_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
         txn_count_q <= txn_count_d;
      end
   end

   assign calc_a    = calc_a_q;
   assign calc_b    = calc_b_q;
   assign calc_op   = calc_op_q;
   assign res_data  = res_data_q;
   assign res_err   = res_err_q;
   assign txn_count = txn_count_q;

endmodule
